icache_2way: RTL and testbench

//  2-way set-associative instruction cache between the IF stage (pc_reg) and inst_rom.

---
 rtl/icache_2way_pkg.sv | 21 ++
 rtl/icache_2way_way.sv | 58 +++++
 rtl/icache_2way.sv | 271 +++++++++++++++++++++++++++
 tb/tb_icache_2way.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_2way_pkg.sv
// icache_2way_pkg
//   Shared types and constants for the 2-way instruction cache.
//   Contents: refill FSM state encoding, data-bus zero constant,
//   a log2 helper that never returns a zero width.
package icache_2way_pkg;

    localparam int          INST_W    = 32;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        IC_IDLE   = 2'd0,
        IC_REFILL = 2'd1,
        IC_DONE   = 2'd2
    } ic_state_e;

    // Counter widths must stay >= 1 even for a count of one.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/icache_2way_way.sv
// icache_way
//   One way of the cache: valid bits, tag array and line data array.
//   Ports:
//     clk, rst            clock, synchronous active-high reset (clears valid bits)
//     clear               synchronous invalidate of every line
//     rd_index, rd_word   combinational lookup address
//     rd_valid, rd_tag,   combinational read of the indexed line
//     rd_data
//     wr_en, wr_index,    synchronous whole-line write; also marks the line valid
//     wr_tag, wr_line
module icache_way
    import icache_2way_pkg::*;
#(
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 22,
    parameter int INDEX_W        = clog2_min1(SETS),
    parameter int WORD_W         = clog2_min1(WORDS_PER_LINE)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear,
    input  logic [INDEX_W-1:0]                 rd_index,
    input  logic [WORD_W-1:0]                  rd_word,
    output logic                               rd_valid,
    output logic [TAG_W-1:0]                   rd_tag,
    output logic [INST_W-1:0]                  rd_data,
    input  logic                               wr_en,
    input  logic [INDEX_W-1:0]                 wr_index,
    input  logic [TAG_W-1:0]                   wr_tag,
    input  logic [WORDS_PER_LINE*INST_W-1:0]   wr_line
);

    logic [SETS-1:0]                  valid_q;
    logic [TAG_W-1:0]                 tag_mem  [SETS];
    logic [WORDS_PER_LINE*INST_W-1:0] line_mem [SETS];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Data and tags carry no reset; the valid bit qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            line_mem[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = line_mem[rd_index][{rd_word, 5'b00000} +: INST_W];

endmodule

// File: rtl/icache_2way.sv
// icache_2way
//   2-way set-associative instruction cache between pc_reg and inst_rom.
//   Hits return the instruction in the same cycle; a miss stalls the
//   pipeline while the line is read word by word from the ROM.
//   Optional feature macro: ICACHE_STATS_EN adds hit/miss counters.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     if_ce_i, if_addr_i       fetch request and word-aligned byte address
//     flush_i                  invalidate all lines, abort any refill
//     inst_o, inst_valid_o     fetched instruction and its qualifier
//     stallreq_o               pipeline stall request
//     rom_ce_o, rom_addr_o     ROM read port
//     rom_inst_i               ROM data (combinational)
//     hit_cnt_o, miss_cnt_o    hit / miss statistics (ICACHE_STATS_EN only)
//   WORDS_PER_LINE must be at least 2.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   IC_IDLE   | lookup; hit answers same cycle, miss latches request
//   IC_REFILL | read line from ROM, MEM_LATENCY cycles per word
//   IC_DONE   | return requested word from line buffer, then idle
module icache_2way
    import icache_2way_pkg::*;
#(
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int MEM_LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        stallreq_o,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int INDEX_W  = clog2_min1(SETS);
    localparam int WORD_W   = clog2_min1(WORDS_PER_LINE);
    localparam int OFFSET_W = WORD_W + 2;
    localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;
    localparam int LAT_W    = clog2_min1(MEM_LATENCY);

    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(MEM_LATENCY - 1);

    ic_state_e state, next_state;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [WORD_W-1:0]  req_word;
    logic               unused_addr_bits;

    logic [TAG_W-1:0]   lat_tag;
    logic [INDEX_W-1:0] lat_index;
    logic [WORD_W-1:0]  lat_word;
    logic               victim_q;

    logic [WORD_W-1:0]  word_cnt;
    logic [LAT_W-1:0]   lat_cnt;
    logic [INST_W-1:0]  line_buf [WORDS_PER_LINE];
    logic [WORDS_PER_LINE*INST_W-1:0] fill_line;

    logic [SETS-1:0]    lru;

    logic               v0, v1;
    logic [TAG_W-1:0]   t0, t1;
    logic [INST_W-1:0]  d0, d1;
    logic               hit0, hit1, hit_any, hit_way, victim;

    logic               lookup_hit, miss_start, word_done, line_done, line_wr;

    assign req_tag          = if_addr_i[31 -: TAG_W];
    assign req_index        = if_addr_i[OFFSET_W +: INDEX_W];
    assign req_word         = if_addr_i[2 +: WORD_W];
    assign unused_addr_bits = ^if_addr_i[1:0];

    assign hit0    = v0 && (t0 == req_tag);
    assign hit1    = v1 && (t1 == req_tag);
    assign hit_any = hit0 || hit1;
    assign hit_way = hit1;

    // Fill empty ways first; only evict by LRU when the set is full.
    assign victim = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru[req_index]);

    // The last word goes straight from the ROM into the array on the
    // same edge it is captured into the line buffer.
    always_comb begin
        fill_line = '0;
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            fill_line[i*INST_W +: INST_W] =
                (word_cnt == WORD_W'(i)) ? rom_inst_i : line_buf[i];
        end
    end

    assign line_wr = line_done && !flush_i && !rst;

    icache_way #(
        .SETS           (SETS),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W),
        .INDEX_W        (INDEX_W),
        .WORD_W         (WORD_W)
    ) u_way0 (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush_i),
        .rd_index (req_index),
        .rd_word  (req_word),
        .rd_valid (v0),
        .rd_tag   (t0),
        .rd_data  (d0),
        .wr_en    (line_wr && !victim_q),
        .wr_index (lat_index),
        .wr_tag   (lat_tag),
        .wr_line  (fill_line)
    );

    icache_way #(
        .SETS           (SETS),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W),
        .INDEX_W        (INDEX_W),
        .WORD_W         (WORD_W)
    ) u_way1 (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush_i),
        .rd_index (req_index),
        .rd_word  (req_word),
        .rd_valid (v1),
        .rd_tag   (t1),
        .rd_data  (d1),
        .wr_en    (line_wr && victim_q),
        .wr_index (lat_index),
        .wr_tag   (lat_tag),
        .wr_line  (fill_line)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IC_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        inst_o       = ZERO_WORD;
        inst_valid_o = 1'b0;
        stallreq_o   = 1'b0;
        rom_ce_o     = 1'b0;
        rom_addr_o   = ZERO_WORD;
        lookup_hit   = 1'b0;
        miss_start   = 1'b0;
        word_done    = 1'b0;
        line_done    = 1'b0;
        if (!rst) begin
            unique case (state)
                IC_IDLE: begin
                    if (if_ce_i && !flush_i) begin
                        if (hit_any) begin
                            inst_o       = hit0 ? d0 : d1;
                            inst_valid_o = 1'b1;
                            lookup_hit   = 1'b1;
                        end else begin
                            stallreq_o = 1'b1;
                            miss_start = 1'b1;
                            next_state = IC_REFILL;
                        end
                    end
                end
                IC_REFILL: begin
                    rom_ce_o   = 1'b1;
                    rom_addr_o = {lat_tag, lat_index, word_cnt, 2'b00};
                    stallreq_o = !flush_i;
                    if (lat_cnt == '0) begin
                        word_done = 1'b1;
                        if (word_cnt == LAST_WORD) begin
                            line_done  = 1'b1;
                            next_state = IC_DONE;
                        end
                    end
                end
                IC_DONE: begin
                    if (!flush_i) begin
                        inst_o       = line_buf[lat_word];
                        inst_valid_o = 1'b1;
                    end
                    next_state = IC_IDLE;
                end
                default: next_state = IC_IDLE;
            endcase
            if (flush_i) begin
                next_state = IC_IDLE;
            end
        end
    end

    // Latency timer is a down-counter: the word is captured when it hits zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt  <= '0;
            lat_cnt   <= '0;
            lat_tag   <= '0;
            lat_index <= '0;
            lat_word  <= '0;
            victim_q  <= 1'b0;
            lru       <= '0;
        end else if (flush_i) begin
            word_cnt <= '0;
            lat_cnt  <= '0;
        end else begin
            if (miss_start) begin
                lat_tag   <= req_tag;
                lat_index <= req_index;
                lat_word  <= req_word;
                victim_q  <= victim;
                word_cnt  <= '0;
                lat_cnt   <= LAT_INIT;
            end
            if (state == IC_REFILL) begin
                if (word_done) begin
                    word_cnt <= word_cnt + 1'b1;
                    lat_cnt  <= LAT_INIT;
                end else begin
                    lat_cnt <= lat_cnt - 1'b1;
                end
            end
            if (lookup_hit) begin
                lru[req_index] <= !hit_way;
            end
            if (line_done) begin
                lru[lat_index] <= !victim_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (word_done && !rst && !flush_i) begin
            line_buf[word_cnt] <= rom_inst_i;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (lookup_hit) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end
            if (miss_start) begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_2way.sv
module tb_icache_2way;

    typedef struct {
        logic        ce;
        logic        flush;
        logic [31:0] addr;
        logic        exp_valid;
        logic        exp_stall;
        logic [31:0] exp_inst;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce;
    logic        flush;
    logic [31:0] if_addr;

    logic [31:0] inst1, inst3, romaddr1, romaddr3, rominst1, rominst3;
    logic        valid1, valid3, stall1, stall3, romce1, romce3;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit1, miss1, hit3, miss3;
`endif

    int checks = 0;
    int errors = 0;
    int sel    = 0;

    logic [31:0] o_inst, o_rom_addr;
    logic        o_valid, o_stall, o_rom_ce;

    vec_t vecs [6];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign rominst1 = rom_fn(romaddr1);
    assign rominst3 = rom_fn(romaddr3);

    always_comb begin
        o_inst     = (sel != 0) ? inst3    : inst1;
        o_valid    = (sel != 0) ? valid3   : valid1;
        o_stall    = (sel != 0) ? stall3   : stall1;
        o_rom_ce   = (sel != 0) ? romce3   : romce1;
        o_rom_addr = (sel != 0) ? romaddr3 : romaddr1;
    end

    icache_2way #(.SETS(64), .WORDS_PER_LINE(4), .MEM_LATENCY(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_ce_i      (if_ce),
        .if_addr_i    (if_addr),
        .flush_i      (flush),
        .inst_o       (inst1),
        .inst_valid_o (valid1),
        .stallreq_o   (stall1),
        .rom_ce_o     (romce1),
        .rom_addr_o   (romaddr1),
        .rom_inst_i   (rominst1)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt_o    (hit1),
        .miss_cnt_o   (miss1)
`endif
    );

    icache_2way #(.SETS(64), .WORDS_PER_LINE(4), .MEM_LATENCY(3)) dut3 (
        .clk          (clk),
        .rst          (rst),
        .if_ce_i      (if_ce),
        .if_addr_i    (if_addr),
        .flush_i      (flush),
        .inst_o       (inst3),
        .inst_valid_o (valid3),
        .stallreq_o   (stall3),
        .rom_ce_o     (romce3),
        .rom_addr_o   (romaddr3),
        .rom_inst_i   (rominst3)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt_o    (hit3),
        .miss_cnt_o   (miss3)
`endif
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one fetch and hold it until inst_valid; checks stall length,
    // the ROM address walk (each word held lat cycles) and the returned word.
    task automatic fetch(input logic [31:0] addr, input int lat, input int exp_stall,
                         input string name);
        int stalls = 0;
        int n      = 0;
        bit got    = 0;
        if_ce   = 1'b1;
        if_addr = addr;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (o_valid) begin
                got = 1;
            end else begin
                if (o_stall) stalls++;
                if (o_rom_ce) begin
                    check32({name, "_rom_addr"}, o_rom_addr,
                            {addr[31:4], 4'h0} + 32'(4 * (n / lat)));
                    n++;
                end
                step();
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_valid expected=inst_valid", name);
        end else begin
            check32({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
            check32({name, "_inst"}, o_inst, rom_fn(addr));
            check32({name, "_rom_ce_at_valid"}, {31'b0, o_rom_ce}, 32'h0);
        end
        step();
        if_ce = 1'b0;
    endtask

    initial begin
        vecs[0] = '{ce: 1'b1, flush: 1'b0, addr: 32'h0, exp_valid: 1'b1, exp_stall: 1'b0, exp_inst: 32'hC0DE_0000};
        vecs[1] = '{ce: 1'b1, flush: 1'b0, addr: 32'hC, exp_valid: 1'b1, exp_stall: 1'b0, exp_inst: 32'hC0DE_000C};
        vecs[2] = '{ce: 1'b0, flush: 1'b0, addr: 32'h4, exp_valid: 1'b0, exp_stall: 1'b0, exp_inst: 32'h0};
        vecs[3] = '{ce: 1'b1, flush: 1'b0, addr: 32'h8, exp_valid: 1'b1, exp_stall: 1'b0, exp_inst: 32'hC0DE_0008};
        vecs[4] = '{ce: 1'b1, flush: 1'b1, addr: 32'h4, exp_valid: 1'b0, exp_stall: 1'b0, exp_inst: 32'h0};
        vecs[5] = '{ce: 1'b1, flush: 1'b0, addr: 32'h4, exp_valid: 1'b0, exp_stall: 1'b1, exp_inst: 32'h0};

        rst     = 1'b1;
        if_ce   = 1'b1;
        flush   = 1'b0;
        if_addr = 32'h0;
        step();
        @(negedge clk);
        check32("rst_stall", {31'b0, stall1}, 32'h0);
        check32("rst_valid", {31'b0, valid1}, 32'h0);
        check32("rst_inst", inst1, 32'h0);
        check32("rst_rom_ce", {31'b0, romce1}, 32'h0);
        check32("rst_rom_addr", romaddr1, 32'h0);
`ifdef ICACHE_STATS_EN
        check32("rst_hit_cnt", hit1, 32'h0);
        check32("rst_miss_cnt", miss1, 32'h0);
`endif
        step();
        rst   = 1'b0;
        if_ce = 1'b0;
        step();

        // cold miss then same-line hits
        fetch(32'h0, 1, 5, "cold_0");
        fetch(32'h4, 1, 0, "hit_4");
        fetch(32'h8, 1, 0, "hit_8");
        fetch(32'hC, 1, 0, "hit_c");
`ifdef ICACHE_STATS_EN
        check32("stats_hit_cnt", hit1, 32'd3);
        check32("stats_miss_cnt", miss1, 32'd1);
`endif

        // single-cycle vectors; the last one starts a refill after a flush
        for (int i = 0; i < 6; i++) begin
            if_ce   = vecs[i].ce;
            flush   = vecs[i].flush;
            if_addr = vecs[i].addr;
            @(negedge clk);
            check32($sformatf("vec%0d_valid", i), {31'b0, valid1}, {31'b0, vecs[i].exp_valid});
            check32($sformatf("vec%0d_stall", i), {31'b0, stall1}, {31'b0, vecs[i].exp_stall});
            check32($sformatf("vec%0d_inst", i), inst1, vecs[i].exp_inst);
            step();
        end
        if_ce = 1'b0;
        flush = 1'b0;
        repeat (8) step();

        // flush during word 2 of a refill
        if_ce   = 1'b1;
        if_addr = 32'h20;
        @(negedge clk);
        check32("fl_miss_stall", {31'b0, stall1}, 32'h1);
        step();
        step();
        step();
        flush = 1'b1;
        if_ce = 1'b0;
        @(negedge clk);
        check32("fl_rom_addr_w2", romaddr1, 32'h28);
        check32("fl_stall", {31'b0, stall1}, 32'h0);
        check32("fl_valid", {31'b0, valid1}, 32'h0);
        step();
        flush = 1'b0;
        @(negedge clk);
        check32("fl_rom_ce_after", {31'b0, romce1}, 32'h0);
        check32("fl_stall_after", {31'b0, stall1}, 32'h0);
        step();
        fetch(32'h20, 1, 5, "fl_refetch");

        // same-set conflict and LRU eviction
        fetch(32'h000, 1, 5, "lru_000");
        fetch(32'h400, 1, 5, "lru_400");
        fetch(32'h800, 1, 5, "lru_800");
        fetch(32'h400, 1, 0, "lru_400_hit");
        fetch(32'h000, 1, 5, "lru_000_miss");

        // longer memory latency
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        sel = 1;
        fetch(32'h100, 3, 13, "lat3_100");
        fetch(32'h108, 3, 0, "lat3_108_hit");
        sel = 0;

        // reset in the middle of a refill
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        if_ce   = 1'b1;
        if_addr = 32'h40;
        @(negedge clk);
        check32("mr_miss_stall", {31'b0, stall1}, 32'h1);
        step();
        step();
        rst   = 1'b1;
        if_ce = 1'b0;
        @(negedge clk);
        check32("mr_rst_stall", {31'b0, stall1}, 32'h0);
        check32("mr_rst_rom_ce", {31'b0, romce1}, 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
`ifdef ICACHE_STATS_EN
        check32("mr_hit_cnt", hit1, 32'h0);
        check32("mr_miss_cnt", miss1, 32'h0);
`endif
        check32("mr_idle_rom_ce", {31'b0, romce1}, 32'h0);
        repeat (6) step();
        fetch(32'h40, 1, 5, "mr_refetch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
